// File: rtl/switch_pio_pkg.sv
// switch_pio_pkg: register map, edge-type codes and a counter sizing helper
// shared by the switch_pio block.
package switch_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Ceiling log2, used to size the per-bit debounce counters
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = 32'(i + 1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_pio_if.sv
// switch_pio_if: Avalon-MM slave bus plus interrupt line of the switch PIO.
interface switch_pio_if #(
    parameter int unsigned WIDTH = 4
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    logic             irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: one input bit - 2-flop synchroniser followed by an
// optional consecutive-cycle debouncer (enabled by SWITCH_PIO_DEBOUNCE_EN).
module switch_debounce
    import switch_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic s1;
    logic s2;

    // Two-flop synchroniser for the asynchronous switch input
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef SWITCH_PIO_DEBOUNCE_EN
    localparam int unsigned       CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Accept s2 only after it has disagreed with stable for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (s2 == stable) begin
            cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= s2;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end
`else
    assign stable = s2;
`endif

endmodule

// File: rtl/switch_pio.sv
// switch_pio: Avalon-MM slave input port for front-panel switches/buttons.
// Per-bit sync + debounce, sticky edge capture (W1C), maskable level irq.
// Build option: define SWITCH_PIO_DEBOUNCE_EN to insert the debouncers;
// otherwise the synchronised input feeds edge detection directly.
module switch_pio
    import switch_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    switch_pio_if.slave      bus
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] w1c_clr;
    logic             wr_en;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw    (in_port[i]),
            .stable (stable[i])
        );
    end

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Edge selection on the debounced state versus its one-cycle delay
    always_comb begin
        edge_hit = stable & ~stable_d;
        if (EDGE_TYPE == EDGE_FALLING) begin
            edge_hit = ~stable & stable_d;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_hit = stable ^ stable_d;
        end
    end

    // Clear mask for EDGECAP write-one-to-clear
    always_comb begin
        w1c_clr = '0;
        if (wr_en && (bus.address == ADDR_EDGECAP)) begin
            w1c_clr = bus.writedata;
        end
    end

    // Control/status registers, read mux and interrupt; new edges win over W1C
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d     <= '0;
            irq_mask     <= '0;
            edge_cap     <= '0;
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
        end else begin
            stable_d <= stable;
            edge_cap <= (edge_cap & ~w1c_clr) | edge_hit;
            if (wr_en && (bus.address == ADDR_IRQMASK)) begin
                irq_mask <= bus.writedata;
            end
            case (bus.address)
                ADDR_DATA:    bus.readdata <= stable;
                ADDR_IRQMASK: bus.readdata <= irq_mask;
                ADDR_EDGECAP: bus.readdata <= edge_cap;
                default:      bus.readdata <= '0;
            endcase
            bus.irq <= |(edge_cap & irq_mask);
        end
    end

endmodule

// File: doc/switch_pio.md
# switch_pio

Parametrised Avalon-MM slave input port for front-panel switches and buttons on the vending-machine board; successor to the single-bit mode-switch input. Synchronises a WIDTH-bit raw input bus and optionally debounces each bit. Captures selected edges per bit in sticky registers, with a maskable level interrupt to the Nios II.

## Interface
- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced bit changes (>=1)
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
- clk  in  1  system clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select, qualifies writes
- write_n  in  1  active-low write strobe
- writedata  in  WIDTH  write data
- in_port  in  WIDTH  raw asynchronous switch inputs
- readdata  out  WIDTH  registered read data
- irq  out  1  registered interrupt request, active high

## Operation
- Register map:
  - 0 DATA (RO): debounced state; writes ignored.
  - 1: reads 0; writes ignored.
  - 2 IRQMASK (RW): per-bit interrupt enable.
  - 3 EDGECAP (W1C): sticky edge flags. Writing 1 clears a bit; writing 0 leaves it unchanged.
- Write is accepted when chipselect=1 and write_n=0. A write with chipselect=0 has no effect.
- Reads have no strobe. readdata <= mux(address) on every clk edge.
- Input path per bit: 2-flop synchroniser (s1, s2) -> debouncer -> stable.
- Debouncer:
  - Counter width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever s2 == stable.
  - While s2 != stable, counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, stable <= s2 and the counter clears.
  - Any pulse on s2 shorter than DEBOUNCE_CYCLES cycles is rejected.
- Edge detect: stable_d is stable delayed one cycle. An edge is detected per EDGE_TYPE from (stable, stable_d).
- EDGECAP bit set has priority over a W1C clear in the same cycle.
- irq <= |(EDGECAP & IRQMASK), registered.
- Unmasked EDGECAP bits still latch. Setting the mask later raises irq on the following edge.
- Reset values: s1, s2, stable, stable_d, counters, IRQMASK, EDGECAP, readdata and irq are all 0.
- Reset mid-debounce discards the partial count.
- An input already high at reset release produces a rising edge after the normal latency. This is the intended power-up behaviour.

## Timing
Edge numbering: in_port change sampled by s1 at edge 1, D = DEBOUNCE_CYCLES.
- s2 changes at edge 2.
- stable changes at edge 2+D.
- EDGECAP bit sets at edge 3+D.
- irq rises at edge 4+D, if the bit is masked in.
- DATA read: address held at edge k -> readdata valid after edge k.
- Write to IRQMASK or EDGECAP at edge k: register updates at edge k; irq reflects it at edge k+1.
- Read of EDGECAP at the same edge as a W1C returns the pre-write value.

## Configuration
- SWITCH_PIO_DEBOUNCE_EN defined: debouncer instantiated as above; DEBOUNCE_CYCLES is honoured.
- SWITCH_PIO_DEBOUNCE_EN undefined:
  - stable = s2 directly; no counters are generated; DEBOUNCE_CYCLES is ignored.
  - Latency becomes: stable at edge 2, EDGECAP at edge 3, irq at edge 4.

## Structure
- Package switch_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2;
  - a clog2 constant function for counter sizing.
- Sub-module switch_debounce: one bit, containing synchroniser, counter and stable flop. Instantiated WIDTH times via generate.
- Top level holds the edge detect, registers, read mux and irq.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated.
- Reset, then read each address -> all reads return 0; irq=0 throughout reset.
- Write IRQMASK=4'b0001, drive in_port[0] 0->1 before edge 1 and hold -> DATA reads 4'b0001 after edge 6; EDGECAP=4'b0001 at edge 7; irq=1 at edge 8.
- in_port[1] 3-cycle high glitch -> DATA, EDGECAP and irq stay 0; a 4-cycle pulse is accepted.
- With EDGECAP=4'b0001 set, write EDGECAP=4'b0000 -> unchanged; write 4'b0001 -> cleared, irq falls one edge later. New edge on the same cycle as the clear -> bit stays 1.
- EDGE_TYPE=2, toggle in_port[2] 0->1->0 with gaps >6 cycles, mask 0 -> EDGECAP[2] latches on both transitions, irq stays 0. Mask 4'b0100 -> irq=1 next edge.
- Assert reset mid-debounce (counter=2) -> all state returns to 0. Without SWITCH_PIO_DEBOUNCE_EN, in_port[0] rise -> irq at edge 4.
